// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing controller.
// Owns the program counter and runs a req/ack handshake to a variable-latency
// instruction memory. Each accepted instruction is handed to IF/ID as a
// one-cycle instr_valid pulse together with its PC+PC_STEP. Branch redirects
// squash wrong-path fetches; a freeze parks a returned word in a hold buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   freeze              IF/ID cannot accept an instruction this cycle
//   br_taken, br_addr   branch redirect from a later stage
//   mem_req, mem_addr   fetch request / address (mem_addr is always pc_reg)
//   mem_ack, mem_rdata  memory response
//   instr_valid         one-cycle pulse: instr_out / pc_out are new
//   instr_out, pc_out   delivered instruction and its PC+PC_STEP
module if_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(PC_STEP);

  // StDrop: a redirect arrived while a request was outstanding; the request
  // cannot be withdrawn, so wait for its ack and throw the data away.
  typedef enum logic [1:0] {StFetch, StDrop, StHold} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [31:0]         hold_q, hold_d;
  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]   pc_inc;

  assign pc_inc = pc_q + PcStep;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    hold_d   = hold_q;
    valid_d  = 1'b0;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;

    unique case (state_q)
      StFetch: begin
        if (br_taken) begin
          if (mem_ack) begin
            pc_d = br_addr;
          end else begin
            target_d = br_addr;
            state_d  = StDrop;
          end
        end else if (mem_ack) begin
          if (freeze) begin
            hold_d  = mem_rdata;
            state_d = StHold;
          end else begin
            valid_d  = 1'b1;
            instr_d  = mem_rdata;
            pc_out_d = pc_inc;
            pc_d     = pc_inc;
          end
        end
      end
      StDrop: begin
        // Latest branch wins, including one coincident with the ack.
        if (br_taken) target_d = br_addr;
        if (mem_ack) begin
          pc_d    = br_taken ? br_addr : target_q;
          state_d = StFetch;
        end
      end
      StHold: begin
        if (br_taken) begin
          pc_d    = br_addr;
          state_d = StFetch;
        end else if (!freeze) begin
          valid_d  = 1'b1;
          instr_d  = hold_q;
          pc_out_d = pc_inc;
          pc_d     = pc_inc;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      target_q <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Drop the request immediately on reset so an abandoned fetch is not held.
  assign mem_req     = !rst && (state_q != StHold);
  assign mem_addr    = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl: a latency-randomizing memory and a
// transaction-level reference model of the fetch stream.
module tb_if_fetch_ctrl;

  localparam int unsigned NumCycles = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .PC_STEP (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_out  (instr_out),
    .pc_out     (pc_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Memory contents: a fixed, address-dependent word.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Reference model: the address to fetch next, whether the in-flight fetch
  // is wrong-path (and where to go after it), and at most one parked word.
  logic [31:0] m_pc;
  bit          m_squash;
  logic [31:0] m_target;
  logic [31:0] m_held[$];
  bit          m_valid;
  logic [31:0] m_iout;
  logic [31:0] m_pout;
  int          m_lat;
  bit          zero_wait;
  int unsigned n_pulses = 0;
  int unsigned n_wraps  = 0;

  function automatic bit exp_req();
    return !rst && (m_held.size() == 0);
  endfunction

  function automatic int new_latency();
    return zero_wait ? 0 : int'($urandom_range(0, 3));
  endfunction

  task automatic deliver(input logic [31:0] w);
    m_valid = 1'b1;
    m_iout  = w;
    m_pout  = m_pc + 32'd4;
    if (m_pout == 32'h0) n_wraps++;
    m_pc    = m_pout;
    n_pulses++;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    bit req;
    req = exp_req();
    if (rst) begin
      m_pc     = 32'h0;
      m_squash = 1'b0;
      m_target = 32'h0;
      m_held.delete();
      m_valid  = 1'b0;
      m_iout   = 32'h0;
      m_pout   = 32'h0;
      m_lat    = new_latency();
      return;
    end
    m_valid = 1'b0;
    if (m_held.size() != 0) begin
      if (br_taken) begin
        m_held.delete();
        m_pc = br_addr;
      end else if (!freeze) begin
        deliver(m_held.pop_front());
      end
    end else if (m_squash) begin
      if (br_taken) m_target = br_addr;
      if (mem_ack) begin
        m_pc     = m_target;
        m_squash = 1'b0;
      end
    end else begin
      if (br_taken) begin
        if (mem_ack) m_pc = br_addr;
        else begin
          m_squash = 1'b1;
          m_target = br_addr;
        end
      end else if (mem_ack) begin
        if (freeze) m_held.push_back(mem_rdata);
        else deliver(mem_rdata);
      end
    end
    if (req) begin
      if (mem_ack) m_lat = new_latency();
      else m_lat--;
    end
  endtask

  function automatic logic [31:0] pick_target();
    unique case ($urandom_range(0, 3))
      0:       return 32'hffff_fff8;
      1:       return 32'hffff_fffc;
      2:       return $urandom & 32'h0000_0ffc;
      default: return $urandom;  // unaligned targets are used as given
    endcase
  endfunction

  initial begin
    zero_wait = 1'b1;
    rst       = 1'b1;
    freeze    = 1'b0;
    br_taken  = 1'b0;
    br_addr   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    model_step();

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clk);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check("instr_out", instr_out, m_iout);
      check("pc_out", pc_out, m_pout);
      check("mem_addr", mem_addr, m_pc);

      zero_wait = (cyc < 24);
      if (cyc < 2) begin
        rst = 1'b1;
      end else if (cyc < 24) begin
        rst      = 1'b0;
        freeze   = 1'b0;
        br_taken = 1'b0;
      end else begin
        rst      = ($urandom_range(0, 149) == 0);
        freeze   = ($urandom_range(0, 2) == 0);
        br_taken = ($urandom_range(0, 7) == 0);
        br_addr  = pick_target();
      end
      mem_ack   = exp_req() && (m_lat <= 0);
      mem_rdata = mem_ack ? instr_of(m_pc) : $urandom;

      #1;
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_req()});
      model_step();
    end

    @(negedge clk);
    check("instr_valid_end", {31'b0, instr_valid}, {31'b0, m_valid});
    check("pc_out_end", pc_out, m_pout);
    if (n_pulses < 100) $display("note: only %0d pulses generated", n_pulses);
    if (n_wraps == 0) $display("note: PC wrap not exercised");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage. Owns the program counter and drives a req/ack handshake to an instruction memory of variable latency.
- Delivers each fetched instruction to the IF/ID register as a one-cycle valid pulse, together with its PC+4.
- Applies branch redirects from later stages and freezes from the hazard unit, discarding wrong-path fetches.
- Replaces the free-running PC/adder/mux path when instruction memory is not single-cycle.

Parameters:
- ADDR_W, 32, width of the PC, branch address and memory address.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per sequential instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- freeze  in  1  hazard stall; IF/ID cannot accept an instruction this cycle.
- br_taken  in  1  branch resolved taken this cycle.
- br_addr  in  ADDR_W  branch target; valid when br_taken=1.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req=1.
- mem_ack  in  1  memory has returned mem_rdata this cycle.
- mem_rdata  in  32  instruction word; valid when mem_ack=1.
- instr_valid  out  1  one-cycle pulse: instr_out and pc_out are new.
- instr_out  out  32  delivered instruction.
- pc_out  out  ADDR_W  PC+PC_STEP of the delivered instruction.

Behaviour:
- Reset: clk and rst are the only clock and reset. With rst=1 at a rising edge, the block loads pc_reg=RESET_PC, state=FETCH, instr_valid=0, instr_out=0, pc_out=0, and clears the redirect flag and hold buffer. mem_req is forced to 0 combinationally while rst=1. Reset during an outstanding request abandons that request; the memory must tolerate mem_req dropping.
- States: FETCH, DROP, HOLD. mem_req=1 in FETCH and DROP. mem_addr=pc_reg at all times.
- Outputs are registered. instr_valid is high exactly one cycle after the accepting edge and 0 otherwise. instr_out and pc_out hold their last values between pulses.
- Priority at every edge: rst, then br_taken, then mem_ack/freeze.
- FETCH:
  - br_taken and mem_ack together: discard rdata; pc_reg<=br_addr; stay in FETCH.
  - br_taken without mem_ack: redirect target <= br_addr; go to DROP. The outstanding request cannot be withdrawn.
  - mem_ack and freeze: hold buffer <= mem_rdata; go to HOLD. pc_reg is unchanged.
  - mem_ack and no freeze: instr_out<=mem_rdata; pc_out<=pc_reg+PC_STEP; instr_valid<=1; pc_reg<=pc_reg+PC_STEP; stay in FETCH.
  - No mem_ack: wait.
- DROP:
  - A further br_taken overwrites the redirect target; the latest branch wins.
  - mem_ack: discard rdata; pc_reg<=target (br_addr if br_taken is high on this edge); go to FETCH.
  - No valid pulse is ever produced in DROP.
- HOLD:
  - mem_req=0.
  - br_taken: discard buffer; pc_reg<=br_addr; go to FETCH.
  - freeze=0: deliver buffer as in the FETCH delivery case; pc_reg+=PC_STEP; go to FETCH.
  - freeze=1: stay in HOLD.
- Throughput: with a zero-wait memory (mem_ack in the same cycle as mem_req), one instruction per cycle. Load-to-use latency is ack edge + 1 cycle.
- Arithmetic: PC increment is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0. br_addr is used unaligned as given.
- freeze in FETCH without mem_ack has no effect.

Test Plan:
- Zero-wait memory, no branches, reset released at cycle 0: mem_addr goes 0,4,8,…. Valid pulses occur every cycle from cycle 1, with pc_out 4,8,12.
- Memory with 2 wait cycles: mem_req stays high with mem_addr=0 for 3 cycles. One valid pulse with pc_out=4 follows, then mem_addr=4.
- Branch during wait: br_taken with br_addr=0x40 while address 8 is pending; ack arrives 2 cycles later. There is no valid pulse for address 8, and the next mem_addr is 0x40.
- Branch coincident with ack at address 0x10, br_addr=0x100: no pulse occurs, and the next mem_addr is 0x100 in the following cycle. Repeat in DROP with a second br_taken to 0x200: the fetch goes to 0x200.
- Freeze held for 3 cycles across an ack of 0xDEADBEEF: mem_req=0 and no pulse while frozen. After release there is one pulse with instr_out=0xDEADBEEF, followed by a br_taken in HOLD discarding the buffer.
- Reset asserted mid-wait at address 0x20: mem_req=0 in the same cycle. After release, mem_addr=RESET_PC and all outputs are 0. Also check the PC wrap from 0xFFFFFFFC to 0.
